// File: rtl/uart_msg_tx.sv
// uart_msg_tx: builds a framed response (PONG/INFO/INVALID/NONCE/ACK) and serializes it as 8N1 UART.
// Latency: start bit of byte 0 on tx_serial the cycle after acceptance; message = bytes*10*DIV cycles.
// Backpressure: req_ready is high only when idle; req_valid while busy is ignored, nothing is queued.
//
// Ports:
//   comm_clk     sole clock
//   reset        asynchronous active-high reset (tx_serial forced high at once)
//   req_valid    response request present
//   req_ready    idle, request will be accepted on the next rising edge if req_valid
//   req_kind     0 PONG, 1 INFO, 2 INVALID, 3 NONCE, 4 ACK, 5-7 treated as INVALID
//   req_payload  32-bit payload for NONCE/ACK, sent MSB byte first
//   tx_serial    registered UART line, idle high
//   busy         message in flight (inverse of req_ready)
//   msg_done     one-cycle pulse in the cycle after the final stop bit
//
// Build option: define UART_MSG_TX_INFO_EN to enable the 16-byte INFO reply.
// Without it, kind 1 sends the INVALID frame and the byte index is only 3 bits.
module uart_msg_tx #(
  parameter int          baud_rate    = 115200,
  parameter int          sys_clk_freq = 50000000,
  parameter logic [31:0] INFO_WORD0   = 32'hdeadbeef,
  parameter logic [31:0] INFO_WORD1   = 32'h13370d13
) (
  input  logic        comm_clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_kind,
  input  logic [31:0] req_payload,
  output logic        tx_serial,
  output logic        busy,
  output logic        msg_done
);

  // Cycles per UART bit; must be at least 2.
  localparam int DIV   = sys_clk_freq / baud_rate;
  localparam int CNT_W = $clog2(DIV);

`ifdef UART_MSG_TX_INFO_EN
  localparam int BYTE_W = 4;
`else
  localparam int BYTE_W = 3;
`endif

  localparam logic [2:0] K_PONG    = 3'd0;
  localparam logic [2:0] K_INFO    = 3'd1;
  localparam logic [2:0] K_INVALID = 3'd2;
  localparam logic [2:0] K_NONCE   = 3'd3;
  localparam logic [2:0] K_ACK     = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic [2:0]          kind_q;
  logic [31:0]         payload_q;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic                accept;

  logic [2:0]          kind_norm;
  logic [BYTE_W-1:0]   last_byte;
  logic [7:0]          cur_byte;
  logic                cnt_last;
  logic [2:0]          bit_next;

`ifndef UART_MSG_TX_INFO_EN
  // INFO words only feed the INFO frame, which is not built in this configuration.
  logic unused_info;
  assign unused_info = ^{INFO_WORD0, INFO_WORD1};
`endif

  // Fold unsupported kinds onto INVALID once, at latch time, so the
  // byte mux and length decode only ever see legal kinds.
  always_comb begin
    kind_norm = K_INVALID;
    case (req_kind)
      K_PONG:  kind_norm = K_PONG;
      K_NONCE: kind_norm = K_NONCE;
      K_ACK:   kind_norm = K_ACK;
`ifdef UART_MSG_TX_INFO_EN
      K_INFO:  kind_norm = K_INFO;
`endif
      default: kind_norm = K_INVALID;
    endcase
  end

  // Index of the final byte of the latched message.
  always_comb begin
    last_byte = BYTE_W'(7);
    case (kind_q)
      K_PONG:  last_byte = '0;
`ifdef UART_MSG_TX_INFO_EN
      K_INFO:  last_byte = BYTE_W'(15);
`endif
      default: last_byte = BYTE_W'(7);
    endcase
  end

  // Byte currently being shifted, selected from kind, index and payload.
  always_comb begin
    cur_byte = 8'h00;
    case (kind_q)
      K_PONG: cur_byte = 8'h01;
      K_NONCE, K_ACK: begin
        case (byte_q)
          BYTE_W'(0): cur_byte = 8'h08;
          BYTE_W'(3): cur_byte = {5'b0, kind_q};
          BYTE_W'(4): cur_byte = payload_q[31:24];
          BYTE_W'(5): cur_byte = payload_q[23:16];
          BYTE_W'(6): cur_byte = payload_q[15:8];
          BYTE_W'(7): cur_byte = payload_q[7:0];
          default:    cur_byte = 8'h00;
        endcase
      end
`ifdef UART_MSG_TX_INFO_EN
      K_INFO: begin
        case (byte_q)
          BYTE_W'(0):  cur_byte = 8'h10;
          BYTE_W'(4):  cur_byte = INFO_WORD0[31:24];
          BYTE_W'(5):  cur_byte = INFO_WORD0[23:16];
          BYTE_W'(6):  cur_byte = INFO_WORD0[15:8];
          BYTE_W'(7):  cur_byte = INFO_WORD0[7:0];
          BYTE_W'(8):  cur_byte = INFO_WORD1[31:24];
          BYTE_W'(9):  cur_byte = INFO_WORD1[23:16];
          BYTE_W'(10): cur_byte = INFO_WORD1[15:8];
          BYTE_W'(11): cur_byte = INFO_WORD1[7:0];
          default:     cur_byte = 8'h00;
        endcase
      end
`endif
      default: begin
        case (byte_q)
          BYTE_W'(0): cur_byte = 8'h08;
          BYTE_W'(3): cur_byte = 8'h01;
          default:    cur_byte = 8'h00;
        endcase
      end
    endcase
  end

  assign cnt_last = (cnt_q == CNT_W'(DIV - 1));
  assign bit_next = bit_q + 3'd1;

  // Next-state logic. tx_d is the line value for the cycle after this edge,
  // so each transition loads the first cycle of the next bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = S_START;
          tx_d    = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      S_START: begin
        if (cnt_last) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = cur_byte[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_next;
            tx_d  = cur_byte[bit_next];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (byte_q == last_byte) begin
            state_d = S_IDLE;
            byte_d  = '0;
            tx_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            // Back-to-back bytes: next start bit follows the stop bit directly.
            byte_d  = byte_q + BYTE_W'(1);
            state_d = S_START;
            tx_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge comm_clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      kind_q    <= K_PONG;
      payload_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      if (accept) begin
        kind_q    <= kind_norm;
        payload_q <= req_payload;
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = ~req_ready;
  assign tx_serial = tx_q;
  assign msg_done  = done_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Bench for uart_msg_tx at DIV=16: directed PONG/NONCE/INFO/ACK/back-to-back/reset cases
// plus random requests, each checked against a byte-list frame model expanded to 8N1 bits.
module tb_uart_msg_tx;

  localparam int DIV = 16;

  logic        comm_clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_kind;
  logic [31:0] req_payload;
  logic        tx_serial;
  logic        busy;
  logic        msg_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_bytes[$];

  uart_msg_tx #(
    .baud_rate   (1),
    .sys_clk_freq(16),
    .INFO_WORD0  (32'hdeadbeef),
    .INFO_WORD1  (32'h13370d13)
  ) dut (
    .comm_clk   (comm_clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_payload(req_payload),
    .tx_serial  (tx_serial),
    .busy       (busy),
    .msg_done   (msg_done)
  );

  always #5 comm_clk = ~comm_clk;

  initial begin
    #5000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: list of bytes in transmission order.
  function automatic void build_frame(input logic [2:0] kind, input logic [31:0] pl);
    logic [31:0] w0, w1;
    w0 = 32'hdeadbeef;
    w1 = 32'h13370d13;
    exp_bytes.delete();
    case (kind)
      3'd0: exp_bytes.push_back(8'h01);
      3'd3, 3'd4: begin
        exp_bytes.push_back(8'h08); exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'h00); exp_bytes.push_back({5'b0, kind});
        for (int i = 3; i >= 0; i--) exp_bytes.push_back(pl[8*i +: 8]);
      end
`ifdef UART_MSG_TX_INFO_EN
      3'd1: begin
        exp_bytes.push_back(8'h10);
        for (int i = 0; i < 3; i++) exp_bytes.push_back(8'h00);
        for (int i = 3; i >= 0; i--) exp_bytes.push_back(w0[8*i +: 8]);
        for (int i = 3; i >= 0; i--) exp_bytes.push_back(w1[8*i +: 8]);
        for (int i = 0; i < 4; i++) exp_bytes.push_back(8'h00);
      end
`endif
      default: begin
        exp_bytes.push_back(8'h08); exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h01);
        for (int i = 0; i < 4; i++) exp_bytes.push_back(8'h00);
      end
    endcase
  endfunction

  // Wait (bounded) for ready, present one request, return on the first start-bit cycle.
  task automatic send(input logic [2:0] kind, input logic [31:0] pl);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 4000) begin
      @(negedge comm_clk);
      n++;
    end
    check("ready_wait", 32'(req_ready), 32'd1);
    req_kind    = kind;
    req_payload = pl;
    req_valid   = 1'b1;
    @(negedge comm_clk);
    req_valid   = 1'b0;
    req_kind    = 3'($urandom);
    req_payload = $urandom;
  endtask

  // Walk the whole message cycle by cycle. mode 1: pulse a NONCE request mid-message.
  // mode 2: raise an INVALID request at cycle 50 and leave it asserted.
  task automatic check_msg(input string tag, input logic [2:0] kind, input logic [31:0] pl,
                           input int mode);
    int   good, not_busy, done_hi, cyc;
    logic exp_bit;
    build_frame(kind, pl);
    cyc      = 0;
    not_busy = 0;
    done_hi  = 0;
    for (int b = 0; b < exp_bytes.size(); b++) begin
      for (int k = 0; k < 10; k++) begin
        if (k == 0)      exp_bit = 1'b0;
        else if (k == 9) exp_bit = 1'b1;
        else             exp_bit = exp_bytes[b][k-1];
        good = 0;
        for (int c = 0; c < DIV; c++) begin
          if (tx_serial === exp_bit) good++;
          if (req_ready !== 1'b0 || busy !== 1'b1) not_busy++;
          if (msg_done !== 1'b0) done_hi++;
          if (mode == 1 && cyc == 100) begin
            req_valid = 1'b1; req_kind = 3'd3; req_payload = $urandom;
          end
          if (mode == 1 && cyc == 101) req_valid = 1'b0;
          if (mode == 2 && cyc == 50) begin
            req_valid = 1'b1; req_kind = 3'd2;
          end
          cyc++;
          @(negedge comm_clk);
        end
        check($sformatf("%s_byte%0d_bit%0d", tag, b, k), 32'(good), 32'(DIV));
      end
    end
    check($sformatf("%s_busy_throughout", tag), 32'(not_busy), 32'd0);
    check($sformatf("%s_no_early_done", tag), 32'(done_hi), 32'd0);
    check($sformatf("%s_msg_done", tag), 32'(msg_done), 32'd1);
    check($sformatf("%s_ready_at_done", tag), 32'(req_ready), 32'd1);
  endtask

  task automatic check_idle(input string tag, input int n);
    int ok;
    ok = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge comm_clk);
      if (tx_serial === 1'b1 && req_ready === 1'b1 && busy === 1'b0 && msg_done === 1'b0) ok++;
    end
    check(tag, 32'(ok), 32'(n));
  endtask

  initial begin
    logic [2:0]  rk;
    logic [31:0] rp;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_kind    = 3'd0;
    req_payload = 32'd0;
    #1;
    check("reset_tx", 32'(tx_serial), 32'd1);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(msg_done), 32'd0);
    repeat (3) @(negedge comm_clk);
    reset = 1'b0;
    check_idle("idle_after_reset", 8);

    send(3'd0, 32'd0);
    check_msg("pong", 3'd0, 32'd0, 0);
    check_idle("idle_after_pong", 4);

    send(3'd3, 32'h38b9b05a);
    check_msg("nonce", 3'd3, 32'h38b9b05a, 0);
    check_idle("idle_after_nonce", 4);

    send(3'd1, 32'h0);
    check_msg("info", 3'd1, 32'h0, 0);
    check_idle("idle_after_info", 4);

    // A NONCE pulsed mid-ACK must be dropped, not queued.
    send(3'd4, 32'h12345678);
    check_msg("ack_intrude", 3'd4, 32'h12345678, 1);
    check_idle("nothing_queued", 3 * DIV);

    // INVALID held across PONG completion starts right after acceptance.
    send(3'd0, 32'd0);
    check_msg("pong_hold", 3'd0, 32'd0, 2);
    @(negedge comm_clk);
    req_valid = 1'b0;
    check_msg("invalid_b2b", 3'd2, 32'd0, 0);
    check_idle("idle_after_b2b", 4);

    // Reset during the third data bit of byte 0 (0x08 bit2 = 0).
    send(3'd2, 32'd0);
    repeat (3 * DIV + 5) @(negedge comm_clk);
    check("pre_reset_tx_low", 32'(tx_serial), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_tx", 32'(tx_serial), 32'd1);
    check("async_reset_ready", 32'(req_ready), 32'd1);
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_done", 32'(msg_done), 32'd0);
    @(negedge comm_clk);
    reset = 1'b0;
    check_idle("idle_after_mid_reset", 2 * DIV);
    send(3'd0, 32'd0);
    check_msg("pong_after_reset", 3'd0, 32'd0, 0);
    check_idle("idle_after_pong2", 4);

    // Random requests, including out-of-range kinds.
    for (int r = 0; r < 6; r++) begin
      rk = 3'($urandom_range(0, 7));
      rp = $urandom;
      send(rk, rp);
      check_msg($sformatf("rand%0d_k%0d", r, rk), rk, rp, 0);
      check_idle($sformatf("rand%0d_idle", r), 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_msg_tx.md
# uart_msg_tx

Response-side message framer and UART serializer for the miner's host link. Accepts one response request at a time from the command decoder or nonce path, builds the framed reply byte stream (PONG, INFO, INVALID, NONCE, ACK) and shifts it out on `tx_serial` as 8N1 UART. Sits between the `uart_comm` command/nonce logic and the FPGA TX pin, all in the `comm_clk` domain.

## Interface
- `baud_rate`, default 115200: line bit rate.
- `sys_clk_freq`, default 50000000: `comm_clk` frequency in Hz. Bit period DIV = `sys_clk_freq`/`baud_rate` (integer, truncated); DIV ≥ 2 required.
- `INFO_WORD0`, default 32'hdeadbeef: first INFO payload word.
- `INFO_WORD1`, default 32'h13370d13: second INFO payload word.

Ports:
- `comm_clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  response request present.
- `req_ready`  out  1  block idle, can accept a request.
- `req_kind`  in  3  0 PONG, 1 INFO, 2 INVALID, 3 NONCE, 4 ACK; 5–7 treated as INVALID.
- `req_payload`  in  32  payload for NONCE/ACK; ignored otherwise.
- `tx_serial`  out  1  UART line, idle high.
- `busy`  out  1  message in flight (inverse of `req_ready`).
- `msg_done`  out  1  one-cycle pulse at message end.

## Operation
- Handshake: request accepted on a rising edge with `req_valid & req_ready`; `req_kind`/`req_payload` are latched then and may change afterwards.
- Message bytes, in transmission order:
  - PONG: 1 byte, 0x01.
  - INFO: 16 bytes, 0x10,0x00,0x00,0x00, `INFO_WORD0`[31:24]..[7:0], `INFO_WORD1`[31:24]..[7:0], then 0x00 ×4.
  - INVALID: 8 bytes, 0x08,0x00,0x00,0x01,0x00,0x00,0x00,0x00.
  - NONCE: 8 bytes, 0x08,0x00,0x00,0x03, then payload[31:24],[23:16],[15:8],[7:0].
  - ACK: 8 bytes, 0x08,0x00,0x00,0x04, then payload bytes in NONCE order.
- Byte frame: start bit 0, data bits LSB first, one stop bit 1.
- FSM: IDLE → START → DATA (8 bits) → STOP → START of the next byte, or IDLE after the last byte.
- Byte index counter 0..15. Byte value comes from a mux on the latched kind, index and payload.
- Bit counter 0..DIV-1. Bit index counter 0..7.

## Timing
- Reset values: `tx_serial`=1, `req_ready`=1, `busy`=0, `msg_done`=0, FSM in IDLE, all counters 0.
- `tx_serial` is registered. The start bit of byte 0 appears the cycle after acceptance.
- Every bit, including start and stop, is held exactly DIV cycles.
- Bytes are back-to-back: the next start bit begins the cycle after the previous stop bit's DIV cycles end. There is no idle gap inside a message.
- Message duration: bytes×10×DIV cycles from the first start-bit cycle.
- When the final stop bit ends, `msg_done` pulses for one cycle and `req_ready` rises in that same cycle. A request presented then is accepted on that edge, so the new start bit follows with no idle bit.
- `req_valid` while busy is ignored; nothing is queued.
- Reset mid-message: `tx_serial` goes to 1 immediately and asynchronously. The in-flight message is dropped, with no partial resume.
- Out-of-range `req_kind` values 5–7 send exactly the INVALID frame.

## Configuration
- `UART_MSG_TX_INFO_EN` defined: kind 1 sends the 16-byte INFO frame and the byte counter is 4 bits wide.
- Not defined: the INFO words are not synthesized, kind 1 sends the INVALID frame, and the byte counter needs only 3 bits (max 8 bytes).

## Test plan
- `sys_clk_freq`=16, `baud_rate`=1 (DIV=16). Request PONG → `tx_serial` low 16 cycles, then bits of 0x01, stop high. `msg_done` fires 160 cycles after the first start cycle.
- Request NONCE with payload 32'h38b9b05a → bytes 08 00 00 03 38 b9 b0 5a back-to-back. Each start bit is sampled low at its mid-bit (cycle 8 of 16).
- INFO with the macro defined → 10 00 00 00 de ad be ef 13 37 0d 13 00 00 00 00. Without the macro, the same request → 08 00 00 01 00 00 00 00.
- Request ACK with payload 32'h12345678. Pulse `req_valid` with NONCE mid-message → only the ACK frame (08 00 00 04 12 34 56 78) is sent; `req_ready` stays 0 until `msg_done`.
- Hold `req_valid` with INVALID across `msg_done` of a PONG → the next start bit begins the cycle after acceptance, and there is no extra idle bit between the two messages.
- Assert `reset` during the third data bit of an INVALID frame → `tx_serial`=1 at once. After release, `req_ready`=1, and a new PONG transmits correctly.
